// File: rtl/acc_burst_pkg.sv
// rtl/acc_burst_pkg.sv - shared types and default sizes for the burst-sum accumulator initiator
package acc_burst_pkg;

  localparam int NR_INPS_DEF = 4;
  localparam int DW_DEF      = 32;

  // Initiator sequencing: collect a frame, replay it, wait for the sum, hand it off
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Operation selector understood by the accumulator; the burst source always requests a sum
  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_NOP  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - NR_INPS x DW frame register file, one write port, combinational read
module frame_buf
  import acc_burst_pkg::*;
#(
  parameter int NR_INPS = NR_INPS_DEF,
  parameter int DW      = DW_DEF,
  parameter int AW      = $clog2(NR_INPS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Rounded up to a power of two so every address value selects a real entry
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next contents: unchanged except for the addressed entry on a write
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage is not reset; a new frame always overwrites every entry before it is replayed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_burst_source.sv
// rtl/acc_burst_source.sv - frame collector, dv-framed burst replay and sum capture; optional ACC_BURST_SOURCE_CHECK_EN adds chk_err
module acc_burst_source
  import acc_burst_pkg::*;
#(
  parameter int NR_INPS    = NR_INPS_DEF,
  parameter int DW         = DW_DEF,
  parameter int RESULT_LAT = NR_INPS + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          acc_dv,
  output logic [DW-1:0] acc_data,
  input  logic [DW-1:0] acc_result,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy
`ifdef ACC_BURST_SOURCE_CHECK_EN
  ,
  output logic          chk_err
`endif
);

  localparam int AW = $clog2(NR_INPS);
  // One counter serves as word index in FILL and as cycles-since-dv in SEND/WAIT
  localparam int CW = $clog2(RESULT_LAT + 1);

  localparam logic [CW-1:0] LAST_WORD = CW'(NR_INPS - 1);
  localparam logic [CW-1:0] CAPTURE   = CW'(RESULT_LAT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_dv_q, acc_dv_d;
  logic [DW-1:0] acc_data_q, acc_data_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;

  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [DW-1:0] buf_rdata;

`ifdef ACC_BURST_SOURCE_CHECK_EN
  logic [DW-1:0] sum_q, sum_d;
  logic          chk_err_q, chk_err_d;
`endif

  assign buf_we    = (state_q == ST_FILL) && s_valid;
  assign buf_waddr = cnt_q[AW-1:0];
  // Registered outputs need the word for the next cycle: buf[0] on entry, buf[k+1] while sending
  assign buf_raddr = (state_q == ST_SEND) ? (cnt_q[AW-1:0] + AW'(1)) : '0;

  frame_buf #(
    .NR_INPS (NR_INPS),
    .DW      (DW),
    .AW      (AW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (s_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Next-state, counter and registered-output decode for the frame sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_dv_d   = 1'b0;
    acc_data_d = '0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
`ifdef ACC_BURST_SOURCE_CHECK_EN
    sum_d      = sum_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          cnt_d = cnt_q + CW'(1);
`ifdef ACC_BURST_SOURCE_CHECK_EN
          sum_d = sum_q + s_data;
`endif
          if (cnt_q == LAST_WORD) begin
            state_d    = ST_SEND;
            cnt_d      = '0;
            acc_dv_d   = 1'b1;
            acc_data_d = buf_rdata;
          end
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_WORD) begin
          state_d = ST_WAIT;
        end else begin
          acc_data_d = buf_rdata;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CAPTURE) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          m_valid_d = 1'b1;
          m_data_d  = acc_result;
`ifdef ACC_BURST_SOURCE_CHECK_EN
          chk_err_d = (acc_result != sum_q);
`endif
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          state_d   = ST_FILL;
          cnt_d     = '0;
          m_valid_d = 1'b0;
`ifdef ACC_BURST_SOURCE_CHECK_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d   = ST_FILL;
        cnt_d     = '0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without telling the accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      acc_dv_q   <= 1'b0;
      acc_data_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
`ifdef ACC_BURST_SOURCE_CHECK_EN
      sum_q      <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_dv_q   <= acc_dv_d;
      acc_data_q <= acc_data_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
`ifdef ACC_BURST_SOURCE_CHECK_EN
      sum_q      <= sum_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  assign s_ready  = (state_q == ST_FILL);
  assign busy     = (state_q != ST_FILL);
  assign acc_dv   = acc_dv_q;
  assign acc_data = acc_data_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
`ifdef ACC_BURST_SOURCE_CHECK_EN
  assign chk_err  = chk_err_q;
`endif

endmodule
